// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one DPRAM access port between the console FSM (r0)
// and the self-test engine (r1); every access runs SETUP -> STROBE -> RELEASE.
module mem_port_arbiter #(
  parameter int AW      = 10,
  parameter int DW      = 16,
  parameter int TIMEOUT = 32
) (
  input  logic          clk,
  input  logic          ar,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic          r0_err,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic          r1_err,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] A,
  output logic [DW-1:0] DIn,
  input  logic [DW-1:0] DOut,
  output logic          RD,
  output logic          WR,
  input  logic          Done,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

  state_t        r_state, w_state;
  logic [AW-1:0] r_a, w_a;
  logic [DW-1:0] r_din, w_din;
  logic [DW-1:0] r_rdata0, w_rdata0;
  logic [DW-1:0] r_rdata1, w_rdata1;
  logic [5:0]    r_cnt, w_cnt;
  logic          r_rd, w_rd;
  logic          r_wr, w_wr;
  logic          r_we, w_we;
  logic          r_busy, w_busy;
  logic          r_owner, w_owner;
  logic          r_last, w_last;
  logic          r_ack0, w_ack0;
  logic          r_ack1, w_ack1;
  logic          r_err0, w_err0;
  logic          r_err1, w_err1;
  logic          w_gnt;

  // Next-state and next-output computation for every registered signal
  always_comb begin
    w_state  = r_state;
    w_a      = r_a;
    w_din    = r_din;
    w_rdata0 = r_rdata0;
    w_rdata1 = r_rdata1;
    w_cnt    = r_cnt;
    w_rd     = r_rd;
    w_wr     = r_wr;
    w_we     = r_we;
    w_busy   = r_busy;
    w_owner  = r_owner;
    w_last   = r_last;
    w_ack0   = 1'b0;
    w_ack1   = 1'b0;
    w_err0   = 1'b0;
    w_err1   = 1'b0;
    w_gnt    = 1'b0;
    case (r_state)
      IDLE: begin
        // On a tie the requester not granted last time wins
        w_gnt = (r0_req && r1_req) ? ~r_last : r1_req;
        if (r0_req || r1_req) begin
          w_we = w_gnt ? r1_we : r0_we;
          w_a  = w_gnt ? r1_addr : r0_addr;
          if (w_we) begin
            w_din = w_gnt ? r1_wdata : r0_wdata;
          end else begin
            w_din = r_din;
          end
          w_owner = w_gnt;
          w_last  = w_gnt;
          w_busy  = 1'b1;
          w_state = SETUP;
        end else begin
          w_state = IDLE;
        end
      end
      SETUP: begin
        w_wr    = r_we;
        w_rd    = ~r_we;
        w_cnt   = 6'd0;
        w_state = STROBE;
      end
      STROBE: begin
        w_cnt = r_cnt + 6'd1;
        if (Done) begin
          w_rd    = 1'b0;
          w_wr    = 1'b0;
          w_ack0  = ~r_owner;
          w_ack1  = r_owner;
          w_state = RELEASE;
          if (!r_we && r_owner) begin
            w_rdata1 = DOut;
          end else if (!r_we) begin
            w_rdata0 = DOut;
          end else begin
            w_rdata0 = r_rdata0;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_rd    = 1'b0;
          w_wr    = 1'b0;
          w_ack0  = ~r_owner;
          w_ack1  = r_owner;
          w_err0  = ~r_owner;
          w_err1  = r_owner;
          w_state = RELEASE;
        end else begin
          w_state = STROBE;
        end
      end
      RELEASE: begin
        // A stuck-high Done holds the port here so no new grant can start
        if (!Done) begin
          w_busy  = 1'b0;
          w_state = IDLE;
        end else begin
          w_state = RELEASE;
        end
      end
      default: begin
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_busy  = 1'b0;
        w_state = IDLE;
      end
    endcase
  end

  // State and output registers; ar clears everything immediately
  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      r_state  <= IDLE;
      r_a      <= {AW{1'b0}};
      r_din    <= {DW{1'b0}};
      r_rdata0 <= {DW{1'b0}};
      r_rdata1 <= {DW{1'b0}};
      r_cnt    <= 6'd0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_we     <= 1'b0;
      r_busy   <= 1'b0;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_a      <= w_a;
      r_din    <= w_din;
      r_rdata0 <= w_rdata0;
      r_rdata1 <= w_rdata1;
      r_cnt    <= w_cnt;
      r_rd     <= w_rd;
      r_wr     <= w_wr;
      r_we     <= w_we;
      r_busy   <= w_busy;
      r_owner  <= w_owner;
      r_last   <= w_last;
      r_ack0   <= w_ack0;
      r_ack1   <= w_ack1;
      r_err0   <= w_err0;
      r_err1   <= w_err1;
    end
  end

  assign A        = r_a;
  assign DIn      = r_din;
  assign RD       = r_rd;
  assign WR       = r_wr;
  assign busy     = r_busy;
  assign owner    = r_owner;
  assign r0_ack   = r_ack0;
  assign r1_ack   = r_ack1;
  assign r0_err   = r_err0;
  assign r1_err   = r_err1;
  assign r0_rdata = r_rdata0;
  assign r1_rdata = r_rdata1;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single DPRAM access port (A, DIn, DOut, RD, WR, Done) between two requesters.
- Requester 0 is the user console FSM; requester 1 is the internal self-test engine.
- Sequences each access with an address/data setup cycle, a strobe phase that waits for Done with a timeout, and a release phase.
- Round-robin arbitration; requesters never drive the memory pins directly.

Parameters:
AW, 10, address width
DW, 16, data width
TIMEOUT, 32, maximum strobe cycles waiting for Done before the access is aborted (legal range 2..63)

Ports:
clk  in  1  system clock, rising edge
ar  in  1  reset, asynchronous, active-high
r0_req  in  1  requester 0 access request (level)
r0_we  in  1  requester 0: 1 = write, 0 = read
r0_addr  in  AW  requester 0 address
r0_wdata  in  DW  requester 0 write data
r0_ack  out  1  requester 0 completion pulse
r0_err  out  1  requester 0 timeout flag (pulses with ack)
r0_rdata  out  DW  requester 0 read data
r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_err, r1_rdata  same as r0_* for requester 1
A  out  AW  memory address
DIn  out  DW  memory write data
DOut  in  DW  memory read data
RD  out  1  memory read strobe
WR  out  1  memory write strobe
Done  in  1  memory access-complete indication (level)
busy  out  1  high in any state other than IDLE
owner  out  1  index of the requester currently or last granted

Behaviour:
- Reset (ar=1, effective immediately, including mid-access):
  - state IDLE; A, DIn, RD, WR, r*_ack, r*_err, r*_rdata, busy all 0.
  - owner=0; last-granted register=1, so requester 0 wins the first tie.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, SETUP, STROBE, RELEASE.
- IDLE:
  - Samples req on each edge.
  - If exactly one req is high, grant it. If both are high, grant the one not last granted; then update last-granted.
  - On grant: latch A←addr and DIn←wdata (DIn loaded only when we=1, otherwise held); latch the op type; owner←index; busy←1; go to SETUP.
- SETUP (exactly 1 cycle): strobes stay low. At exit, assert WR (write) or RD (read), clear the timeout counter, go to STROBE.
- STROBE:
  - Increment the counter each cycle.
  - If Done=1: deassert RD/WR; on a read, capture DOut into the owner's rdata; pulse the owner's ack for 1 cycle; go to RELEASE.
  - Otherwise, when the counter reaches TIMEOUT-1: deassert the strobe; pulse ack and err together; rdata is not updated; go to RELEASE.
  - Done is checked first: if Done and the timeout occur in the same cycle, the access is a success.
- RELEASE:
  - Lasts at least 1 cycle (the ack cycle).
  - Stays until Done=0, then goes to IDLE with busy←0.
  - Done stuck high holds the arbiter in RELEASE; no new grant is made.
- Requester contract:
  - Hold req, we, addr, wdata stable from req rise until ack.
  - Drop req on the edge after seeing ack.
  - req still high when IDLE is re-entered is treated as a new access.
  - req is ignored outside IDLE.
  - Deasserting req after grant does not abort the access.
- Latency: grant edge to strobe = 2 edges. Minimum access from grant to ack = 3 cycles (Done high on the first STROBE cycle). Minimum back-to-back spacing = 4 cycles.
- rdata holds its value until the next successful read by the same requester. Writes do not alter rdata.
- A and DIn hold their last values while IDLE.
- ack and err for the non-owner are always 0. Both acks are never high in the same cycle.

Test Plan:
- Single write, Done one cycle after strobe: r0 write 0x3FF←0xBEEF → A=0x3FF, DIn=0xBEEF, WR high 2 cycles, r0_ack one pulse, r0_err=0, RD never high.
- Single read: r1 reads 0x005, model returns DOut=0x004B with Done → r1_rdata=0x004B on the r1_ack cycle; r0_rdata unchanged.
- Contention: r0 and r1 raise req on the same edge, each holding for 3 accesses → grants alternate 0,1,0,1,0,1; owner tracks each grant; no ack overlap.
- Timeout: Done held 0, r0 write → WR high exactly TIMEOUT cycles; r0_ack=r0_err=1 for one cycle; return to IDLE.
- Reset mid-access: assert ar during STROBE with RD=1 → RD, busy, A, DIn go to 0 without waiting for a clock; after release, a tie is won by r0.
- Done stuck high after completion → stays in RELEASE, pending r1_req not granted; drop Done → IDLE next edge, r1 granted on the following edge.
